// File: rtl/music_pkg.sv
// music_pkg: note half-periods, track table and amplitude table for music_player
package music_pkg;
  localparam logic [19:0] REST = 20'd0;
  localparam logic [19:0] C4 = 20'd191113;
  localparam logic [19:0] D4 = 20'd170262;
  localparam logic [19:0] E4 = 20'd151686;
  localparam logic [19:0] F4 = 20'd143173;
  localparam logic [19:0] G4 = 20'd127552;
  localparam logic [19:0] A4 = 20'd113636;
  localparam logic [19:0] B4 = 20'd101239;
  localparam logic [19:0] C5 = 20'd95557;
  localparam logic [19:0] TUNES [4][8] = '{
    '{C4, E4, G4, C5, G4, E4, C4, REST},
    '{A4, C5, B4, A4, F4, A4, REST, A4},
    '{E4, D4, C4, D4, E4, E4, E4, REST},
    '{G4, G4, A4, G4, C5, B4, REST, REST}
  };
  // Each track is an 8-note phrase; the second half of the song plays it an octave up.
  // The test table gives short half-periods so a bench can watch whole cycles quickly.
  function automatic logic [19:0] track_note(input logic [1:0] track, input logic [5:0] idx, input logic test);
    return test ? (idx == 6'd0 ? 20'd5 : idx == 6'd1 ? REST : {17'd0, 3'd4 + {1'b0, track}})
         : idx[5] ? TUNES[track][idx[2:0]] >> 1 : TUNES[track][idx[2:0]];
  endfunction
  function automatic logic [15:0] amplitude(input logic [2:0] level);
    return level == 3'd1 ? 16'h0400 : level == 3'd2 ? 16'h0800 : level == 3'd3 ? 16'h1000
         : level == 3'd4 ? 16'h2000 : level == 3'd5 ? 16'h4000 : 16'h0000;
  endfunction
endpackage

// File: rtl/music_player_if.sv
// music_player_if: control inputs and audio/status outputs of music_player
interface music_player_if;
  logic [3:0] state;
  logic vol_up;
  logic vol_down;
  logic mute;
  logic signed [15:0] audio_in_left;
  logic signed [15:0] audio_in_right;
  logic [2:0] volume;
  logic [5:0] note_idx;
  modport master(output state, vol_up, vol_down, mute,
                 input audio_in_left, audio_in_right, volume, note_idx);
  modport slave(input state, vol_up, vol_down, mute,
                output audio_in_left, audio_in_right, volume, note_idx);
endinterface

// File: rtl/note_gen.sv
// note_gen: square-wave phase generator for a half-period given in clock cycles
module note_gen
  import music_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] half_period,
  output logic        phase
);
  logic [19:0] cnt;
  logic [19:0] prev;
  // Restart on reset, on a new note or during a rest; otherwise flip phase every half_period cycles
  always_ff @(posedge clk) begin
    prev <= half_period;
    if (rst || half_period != prev || half_period == REST) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == half_period - 20'd1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else
      cnt <= cnt + 20'd1;
  end
endmodule

// File: rtl/music_player.sv
// music_player: beat-stepped track playback with volume, mute and registered stereo samples
module music_player
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_HZ     = 8,
  parameter int SONG_LEN    = 64,
  parameter int VOL_DEFAULT = 3,
  parameter int VOL_MAX     = 5,
  parameter bit TEST_ROM    = 1'b0
) (
  input logic clk,
  input logic rst,
  music_player_if.slave io
);
  localparam int BEAT_N = CLK_HZ / BEAT_HZ;
  localparam int BW = $clog2(BEAT_N);
  logic [BW-1:0] beat;
  logic [1:0] trk_q;
  logic [5:0] idx;
  logic [2:0] vol;
  logic [15:0] audio;
  logic [19:0] half;
  logic phase, trk_chg, tick, unused;
  assign trk_chg = io.state[1:0] != trk_q;
  assign tick = beat == BW'(BEAT_N - 1);
  assign half = track_note(io.state[1:0], idx, TEST_ROM);
  assign unused = ^io.state[3:2];
  // A track switch restarts the square wave together with the song position
  note_gen u_gen (.clk(clk), .rst(rst || trk_chg), .half_period(half), .phase(phase));
  // Beat divider and note position; a track switch wins over a coincident tick
  always_ff @(posedge clk) begin
    trk_q <= io.state[1:0];
    if (rst) begin
      beat <= '0;
      idx  <= '0;
    end else begin
      beat <= (trk_chg || tick) ? '0 : beat + BW'(1);
      idx  <= trk_chg ? '0 : tick ? (idx == 6'(SONG_LEN - 1) ? '0 : idx + 6'd1) : idx;
    end
  end
  // Saturating volume level and the registered output sample
  always_ff @(posedge clk) begin
    if (rst) begin
      vol   <= 3'(VOL_DEFAULT);
      audio <= '0;
    end else begin
      audio <= (io.mute || half == REST) ? '0 : phase ? amplitude(vol) : -amplitude(vol);
      if (io.vol_up && !io.vol_down && vol != 3'(VOL_MAX)) vol <= vol + 3'd1;
      else if (io.vol_down && !io.vol_up && vol != 3'd1) vol <= vol - 3'd1;
    end
  end
  assign io.audio_in_left = audio;
  assign io.audio_in_right = audio;
  assign io.volume = vol;
  assign io.note_idx = idx;
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: cycle model plus directed literal checks for music_player
module tb_music_player;
  localparam int BN = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  music_player_if io ();
  music_player #(.CLK_HZ(1000), .BEAT_HZ(10), .TEST_ROM(1'b1)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, ecount = 0;
  bit chk_en = 1'b0;
  int m_t = 0, m_seg = 0, m_hprev = 0, m_vol = 3;
  logic [1:0] m_trk = 2'd0;
  logic [15:0] m_audio = 16'd0;

  function automatic int rom(int trk, int idx);
    return idx == 0 ? 5 : idx == 1 ? 0 : 4 + trk;
  endfunction

  function automatic logic [15:0] amp(int v);
    logic [15:0] base;
    base = 16'h0400;
    return base << (v - 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(logic up, logic down);
    io.vol_up = up;
    io.vol_down = down;
    step(1);
    io.vol_up = 1'b0;
    io.vol_down = 1'b0;
  endtask

  task automatic wait_ec(int target);
    int k = 0;
    while (ecount != target && k < 10000) begin
      step(1);
      k++;
    end
    if (ecount != target) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ec: got %0d expected %0d", ecount, target);
    end
  endtask

  always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

  // Behavioural model: song time, time since the square last restarted, clamped volume
  always @(posedge clk) begin
    int h;
    bit ph, chg;
    h = rom(int'(io.state[1:0]), (m_t / BN) % 64);
    ph = (m_seg != 0) && ((m_seg / m_hprev) % 2 == 1);
    if (rst) begin
      m_t = 0;
      m_seg = 0;
      m_vol = 3;
      m_audio = 16'd0;
    end else begin
      m_audio = (io.mute || h == 0) ? 16'd0 : ph ? amp(m_vol) : ~amp(m_vol) + 16'd1;
      chg = io.state[1:0] != m_trk;
      m_seg = (chg || h != m_hprev || h == 0) ? 0 : m_seg + 1;
      m_t = chg ? 0 : m_t + 1;
      m_vol = m_vol + int'(io.vol_up) - int'(io.vol_down);
      m_vol = m_vol > 5 ? 5 : m_vol < 1 ? 1 : m_vol;
    end
    m_hprev = h;
    m_trk = io.state[1:0];
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("audio_l", {16'h0, io.audio_in_left}, {16'h0, m_audio});
      check("audio_r", {16'h0, io.audio_in_right}, {16'h0, m_audio});
      check("volume", {29'h0, io.volume}, 32'(m_vol));
      check("note_idx", {26'h0, io.note_idx}, 32'((m_t / BN) % 64));
    end
  end

  initial begin
    io.state = 4'd0;
    io.vol_up = 1'b0;
    io.vol_down = 1'b0;
    io.mute = 1'b0;
    step(2);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_audio", {16'h0, io.audio_in_left}, 32'h0);
    check("rst_volume", {29'h0, io.volume}, 32'd3);
    check("rst_idx", {26'h0, io.note_idx}, 32'd0);
    step(1);
    check("sq_n1", {16'h0, io.audio_in_left}, 32'hF000);
    step(4);
    check("sq_n5", {16'h0, io.audio_in_left}, 32'hF000);
    step(1);
    check("sq_n6", {16'h0, io.audio_in_left}, 32'h1000);
    step(4);
    check("sq_n10", {16'h0, io.audio_in_left}, 32'h1000);
    step(1);
    check("sq_n11", {16'h0, io.audio_in_left}, 32'hF000);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0);
      check("vol_up", {29'h0, io.volume}, i == 0 ? 32'd4 : 32'd5);
    end
    step(1);
    check("amp_max", 32'(io.audio_in_left == 16'h4000 || io.audio_in_left == 16'hC000), 32'd1);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 1'b1);
      check("vol_down", {29'h0, io.volume}, 4 - i < 1 ? 32'd1 : 32'(4 - i));
    end
    step(1);
    check("amp_min", 32'(io.audio_in_left == 16'h0400 || io.audio_in_left == 16'hFC00), 32'd1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("vol_both", {29'h0, io.volume}, 32'd2);
    io.mute = 1'b1;
    step(1);
    check("mute_audio", {16'h0, io.audio_in_left}, 32'h0);
    check("mute_vol", {29'h0, io.volume}, 32'd2);
    step(3);
    io.mute = 1'b0;
    step(1);
    check("unmute_amp", 32'(io.audio_in_left == 16'h0800 || io.audio_in_left == 16'hF800), 32'd1);
    io.state = 4'd4;
    wait_ec(99);
    check("beat_pre", {26'h0, io.note_idx}, 32'd0);
    step(1);
    check("beat_tick", {26'h0, io.note_idx}, 32'd1);
    wait_ec(150);
    check("rest_audio", {16'h0, io.audio_in_left}, 32'h0);
    wait_ec(6399);
    check("idx_63", {26'h0, io.note_idx}, 32'd63);
    step(1);
    check("idx_wrap", {26'h0, io.note_idx}, 32'd0);
    wait_ec(6750);
    io.state = 4'd1;
    step(1);
    check("trk_restart", {26'h0, io.note_idx}, 32'd0);
    step(98);
    check("trk_beat98", {26'h0, io.note_idx}, 32'd0);
    step(1);
    check("trk_beat99", {26'h0, io.note_idx}, 32'd0);
    io.state = 4'd2;
    step(1);
    check("trk_vs_tick", {26'h0, io.note_idx}, 32'd0);
    step(99);
    check("trk2_pre", {26'h0, io.note_idx}, 32'd0);
    step(1);
    check("trk2_tick", {26'h0, io.note_idx}, 32'd1);
    step(100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_audio", {16'h0, io.audio_in_left}, 32'h0);
    check("midrst_vol", {29'h0, io.volume}, 32'd3);
    check("midrst_idx", {26'h0, io.note_idx}, 32'd0);
    step(20);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Generates the background-music samples for the board's audio path.
- Sits directly upstream of speaker_control and drives its audio_in_left and audio_in_right inputs.
- Selects a track from the game state and steps through notes at a fixed beat rate.
- Synthesises a square wave per note, scales it by a user volume level (BTNU/BTND one-pulses), and honours the mute switch (SW14).

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; sets the beat divider.
- BEAT_HZ, 8, note steps per second; beat period = CLK_HZ/BEAT_HZ cycles.
- SONG_LEN, 64, notes per track; note index wraps at SONG_LEN-1.
- VOL_DEFAULT, 3, volume level loaded at reset (1..VOL_MAX).
- VOL_MAX, 5, highest volume level.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- state  in  4  game state; track = state[1:0]
- vol_up  in  1  single-cycle pulse, volume +1
- vol_down  in  1  single-cycle pulse, volume -1
- mute  in  1  level; 1 forces silence
- audio_in_left  out  16  signed sample to speaker_control
- audio_in_right  out  16  signed sample, always equal to left
- volume  out  3  current level 1..VOL_MAX (LED display)
- note_idx  out  6  current note position (debug)

Behaviour:
- Reset (rst=1 at a clk edge):
  - audio_in_left/right=0, volume=VOL_DEFAULT, note_idx=0.
  - Beat counter, half-period counter and square phase all 0.
  - Reset mid-note clears everything on that same edge.
- Beat counter:
  - Counts 0..CLK_HZ/BEAT_HZ-1, then wraps.
  - The wrap cycle is the tick; on a tick note_idx increments, and SONG_LEN-1 wraps to 0.
- Track change:
  - If state[1:0] differs from the registered value from the previous cycle, then on the next edge note_idx=0, beat counter=0, half-period counter=0, phase=0.
  - Track change takes priority over a simultaneous tick.
- Note ROM:
  - Combinational lookup (track, note_idx) -> 20-bit half_period in clk cycles.
  - half_period=0 means rest.
- Square generator:
  - Counter increments each cycle.
  - When counter == half_period-1: counter returns to 0 and phase toggles.
  - Whenever half_period changes (new note), counter and phase clear on that edge.
  - During a rest, counter and phase are held at 0.
- Amplitude, by volume level:
  - 1 -> 16'h0400
  - 2 -> 16'h0800
  - 3 -> 16'h1000
  - 4 -> 16'h2000
  - 5 -> 16'h4000
- Sample output:
  - phase=1 gives +amp; phase=0 gives -amp (two's complement, e.g. 16'hF000 for level 3).
  - Output is 0 when mute=1 or during a rest.
  - audio_in_left/right are registered, so a phase, volume or mute change is visible 1 cycle later.
- Volume:
  - vol_up increments, saturating at VOL_MAX.
  - vol_down decrements, saturating at 1.
  - vol_up and vol_down in the same cycle: no change.
  - Mute never modifies the volume register.
- Width rules:
  - Half-period counter is 20 bits, enough for notes down to ~48 Hz at 100 MHz.
  - No arithmetic overflow path exists.

Decomposition:
- Shared package music_pkg:
  - Half-period constants per note name (e.g. C4=191113, A4=113636).
  - The 4x SONG_LEN track table as a function.
  - The amplitude table as a function.
  - Constant REST=0.
- One sub-module, note_gen:
  - Inputs: clk, rst, half_period.
  - Output: phase.
  - Contains the counter, toggle and clear-on-change logic.
- music_player holds the beat counter, track detect, volume register and output register.

Test Plan:
- Bench uses CLK_HZ=1000, BEAT_HZ=10 (100-cycle beat), with track 0 note 0 forced to half_period 5 via a test ROM.
- Scenario 1: release rst with mute=0 -> after reset audio=0 and volume=3; phase toggles every 5 cycles, so audio alternates 16'h1000 / 16'hF000 with a 10-cycle period, lagging phase by 1 cycle.
- Scenario 2: run 100 cycles -> note_idx goes 0 -> 1 exactly on the beat wrap; after 64 beats note_idx wraps 63 -> 0.
- Scenario 3: pulse vol_up 4 times -> volume goes 4, 5, 5, 5 and amplitude becomes 16'h4000; then pulse vol_down 6 times -> volume ends at 1 and amplitude is 16'h0400; a cycle with both pulses leaves volume unchanged.
- Scenario 4: assert mute mid-note -> audio is 0 one cycle later while volume is unchanged; deassert -> ±amp resumes with the phase undisturbed.
- Scenario 5: change state from 0 to 4 mid-beat (track 0 unchanged) -> no restart; change state 4 to 1 -> note_idx=0 and beat counter=0 on the following edge, even when coincident with a tick.
- Scenario 6: hit a rest entry, and separately assert rst mid-note -> rest gives audio 0 with phase held at 0; rst clears all state on that edge, audio=0 and volume=3 the next cycle.
